// File: rtl/mem_access_stage_pkg.sv
// Shared pipeline definitions for the MEM stage.
//   DATA_W / REG_ADDR_W : datapath and register-index widths common to EX/MEM/WB
//   state_e             : MEM access FSM encoding
//   ALUOP_*             : ALUOp codes shared with the EX stage
//   mem_op_illegal()    : flags a memory op the stage refuses to perform
package mem_access_stage_pkg;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_e;

    localparam logic [1:0] ALUOP_LW_SW_ADDI = 2'b00;
    localparam logic [1:0] ALUOP_BEQ        = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE      = 2'b10;

    // A load and a store at once is meaningless, and only word-aligned
    // addresses are supported.
    function automatic logic mem_op_illegal(input logic       rd,
                                            input logic       wr,
                                            input logic [1:0] byte_off);
        return (rd && wr) || ((rd || wr) && (byte_off != 2'b00));
    endfunction

endpackage

// File: rtl/mem_access_stage_dmem_bank.sv
// Word-addressed data memory for the MEM stage.
//   clk    : clock, rising edge
//   we     : write enable; wdata is written to mem[waddr] on the edge
//   waddr  : write word address
//   wdata  : write data
//   raddr  : read word address, sampled every edge
//   rdata  : registered read data (mem[raddr] as of the previous edge)
// The array has no reset so its contents survive a pipeline reset.
module dmem_bank #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DATA_W-1:0] rdata_d;
    logic [DATA_W-1:0] rdata_q;

    always_comb begin
        rdata_d = mem[raddr];
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mem_access_stage.sv
// Pipeline MEM stage: uses the EX result as a data-memory word address and
// performs loads/stores through a fixed-latency access FSM, otherwise forwards
// the ALU value to writeback.
//   clk, reset   : clock (rising edge), asynchronous active-high reset
//   stall_in     : bubble from EX, no operation performed
//   alu_result   : byte address for load/store, or value to write back
//   store_data   : data written on a store
//   mem_read     : load
//   mem_write    : store
//   reg_write_in : instruction writes a register
//   rd_in        : destination register
//   busy         : access in flight, EX must hold its outputs stable
//   stall_out    : registered bubble flag to WB
//   wb_en        : one-cycle pulse, wb_data/wb_rd valid
//   wb_data      : load data or forwarded alu_result
//   wb_rd        : destination register
//   err          : sticky, set by a misaligned or read+write memory op
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int DATA_W  = mem_access_stage_pkg::DATA_W,
    parameter int ADDR_W  = 8,
    parameter int MEM_LAT = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall_in,
    input  logic [DATA_W-1:0]     alu_result,
    input  logic [DATA_W-1:0]     store_data,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic                  reg_write_in,
    input  logic [REG_ADDR_W-1:0] rd_in,
    output logic                  busy,
    output logic                  stall_out,
    output logic                  wb_en,
    output logic [DATA_W-1:0]     wb_data,
    output logic [REG_ADDR_W-1:0] wb_rd,
    output logic                  err
);

    localparam int CNT_W = 4;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [DATA_W-1:0]     sdata_q, sdata_d;
    logic [REG_ADDR_W-1:0] rd_q, rd_d;
    logic                  is_store_q, is_store_d;
    logic                  busy_q, busy_d;
    logic                  stall_q, stall_d;
    logic                  wb_en_q, wb_en_d;
    logic [DATA_W-1:0]     wb_data_q, wb_data_d;
    logic [REG_ADDR_W-1:0] wb_rd_q, wb_rd_d;
    logic                  err_q, err_d;

    logic                  illegal;
    logic                  last_cycle;
    logic                  mem_we;
    logic [ADDR_W-1:0]     mem_raddr;
    logic [DATA_W-1:0]     mem_rdata;

    assign illegal    = mem_op_illegal(mem_read, mem_write, alu_result[1:0]);
    assign last_cycle = (state_q == ST_ACCESS) && (cnt_q == '0);

    // The write strobe is decoded from registered state only, so an async
    // reset during ACCESS can never produce a partial or late write.
    assign mem_we = last_cycle && is_store_q;

    // In IDLE the bank reads the incoming address so that a MEM_LAT of 1
    // still has valid data at completion; in ACCESS it keeps re-reading the
    // captured word, which picks up a store completed just before acceptance.
    assign mem_raddr = (state_q == ST_IDLE) ? alu_result[ADDR_W+1:2] : addr_q;

    dmem_bank #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_dmem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (addr_q),
        .wdata (sdata_q),
        .raddr (mem_raddr),
        .rdata (mem_rdata)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        sdata_d    = sdata_q;
        rd_d       = rd_q;
        is_store_d = is_store_q;
        busy_d     = busy_q;
        stall_d    = stall_q;
        wb_en_d    = 1'b0;
        wb_data_d  = wb_data_q;
        wb_rd_d    = wb_rd_q;
        err_d      = err_q;

        case (state_q)
            ST_IDLE: begin
                if (stall_in) begin
                    stall_d = 1'b1;
                end else if (mem_read || mem_write) begin
                    stall_d = 1'b0;
                    if (illegal) begin
                        err_d = 1'b1;
                    end else begin
                        addr_d     = alu_result[ADDR_W+1:2];
                        sdata_d    = store_data;
                        rd_d       = rd_in;
                        is_store_d = mem_write;
                        cnt_d      = CNT_W'(MEM_LAT - 1);
                        busy_d     = 1'b1;
                        state_d    = ST_ACCESS;
                    end
                end else begin
                    stall_d   = 1'b0;
                    wb_data_d = alu_result;
                    wb_rd_d   = rd_in;
                    wb_en_d   = reg_write_in;
                end
            end
            ST_ACCESS: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    if (!is_store_q) begin
                        wb_data_d = mem_rdata;
                        wb_rd_d   = rd_q;
                        wb_en_d   = 1'b1;
                    end
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            sdata_q    <= '0;
            rd_q       <= '0;
            is_store_q <= 1'b0;
            busy_q     <= 1'b0;
            stall_q    <= 1'b0;
            wb_en_q    <= 1'b0;
            wb_data_q  <= '0;
            wb_rd_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            sdata_q    <= sdata_d;
            rd_q       <= rd_d;
            is_store_q <= is_store_d;
            busy_q     <= busy_d;
            stall_q    <= stall_d;
            wb_en_q    <= wb_en_d;
            wb_data_q  <= wb_data_d;
            wb_rd_q    <= wb_rd_d;
            err_q      <= err_d;
        end
    end

    assign busy      = busy_q;
    assign stall_out = stall_q;
    assign wb_en     = wb_en_q;
    assign wb_data   = wb_data_q;
    assign wb_rd     = wb_rd_q;
    assign err       = err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage (MEM_LAT=2, ADDR_W=8).
module tb_mem_access_stage;

    logic        clk;
    logic        reset;
    logic        stall_in;
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write_in;
    logic [4:0]  rd_in;
    logic        busy;
    logic        stall_out;
    logic        wb_en;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic        err;

    int checks = 0;
    int errors = 0;

    mem_access_stage #(
        .DATA_W  (32),
        .ADDR_W  (8),
        .MEM_LAT (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .stall_in     (stall_in),
        .alu_result   (alu_result),
        .store_data   (store_data),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .reg_write_in (reg_write_in),
        .rd_in        (rd_in),
        .busy         (busy),
        .stall_out    (stall_out),
        .wb_en        (wb_en),
        .wb_data      (wb_data),
        .wb_rd        (wb_rd),
        .err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        string       name;
        logic        stall;
        logic [31:0] alu;
        logic [31:0] sdata;
        logic [4:0]  rd;
        logic        mr;
        logic        mw;
        logic        rw;
        logic        e_wb_en;
        logic        chk_wb;
        logic [31:0] e_data;
        logic [4:0]  e_rd;
        logic        e_stall;
        logic        e_err;
    } vec_t;

    function automatic vec_t mk(input string n, input logic st, input logic [31:0] a,
                                input logic [31:0] sd, input logic [4:0] r,
                                input logic mr, input logic mw, input logic rw,
                                input logic ewe, input logic cw, input logic [31:0] ed,
                                input logic [4:0] er, input logic es, input logic ee);
        vec_t v;
        v.name = n; v.stall = st; v.alu = a; v.sdata = sd; v.rd = r;
        v.mr = mr; v.mw = mw; v.rw = rw;
        v.e_wb_en = ewe; v.chk_wb = cw; v.e_data = ed; v.e_rd = er;
        v.e_stall = es; v.e_err = ee;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic nop();
        stall_in     = 1'b0;
        alu_result   = '0;
        store_data   = '0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        reg_write_in = 1'b0;
        rd_in        = '0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".busy"},      {31'd0, busy},      32'd0);
        check({tag, ".stall_out"}, {31'd0, stall_out}, 32'd0);
        check({tag, ".wb_en"},     {31'd0, wb_en},     32'd0);
        check({tag, ".wb_data"},   wb_data,            32'd0);
        check({tag, ".wb_rd"},     {27'd0, wb_rd},     32'd0);
        check({tag, ".err"},       {31'd0, err},       32'd0);
    endtask

    // Store: accepted at edge N, busy through N+1, completes at N+2.
    task automatic do_store(input string tag, input logic [31:0] addr, input logic [31:0] data);
        nop();
        alu_result = addr;
        store_data = data;
        mem_write  = 1'b1;
        step();
        check({tag, ".busy_n"},  {31'd0, busy},  32'd1);
        check({tag, ".wb_en_n"}, {31'd0, wb_en}, 32'd0);
        step();
        check({tag, ".busy_n1"}, {31'd0, busy},  32'd1);
        step();
        check({tag, ".busy_n2"}, {31'd0, busy},  32'd0);
        check({tag, ".wb_en_n2"}, {31'd0, wb_en}, 32'd0);
        nop();
    endtask

    // Load: wb_en pulses exactly at edge N+2 and drops the next cycle.
    task automatic do_load(input string tag, input logic [31:0] addr, input logic [4:0] rd,
                           input logic [31:0] exp);
        nop();
        alu_result = addr;
        rd_in      = rd;
        mem_read   = 1'b1;
        step();
        check({tag, ".busy_n"},   {31'd0, busy},  32'd1);
        check({tag, ".wb_en_n"},  {31'd0, wb_en}, 32'd0);
        step();
        check({tag, ".wb_en_n1"}, {31'd0, wb_en}, 32'd0);
        step();
        check({tag, ".wb_en_n2"}, {31'd0, wb_en}, 32'd1);
        check({tag, ".busy_n2"},  {31'd0, busy},  32'd0);
        check({tag, ".wb_data"},  wb_data,        exp);
        check({tag, ".wb_rd"},    {27'd0, wb_rd}, {27'd0, rd});
        nop();
        step();
        check({tag, ".wb_en_n3"}, {31'd0, wb_en}, 32'd0);
    endtask

    vec_t vecs[7];

    initial begin
        vecs[0] = mk("rtype_pass",  1'b0, 32'h0000_0007, 32'h0, 5'd3,  1'b0, 1'b0, 1'b1,
                     1'b1, 1'b1, 32'h0000_0007, 5'd3,  1'b0, 1'b0);
        vecs[1] = mk("no_regwrite", 1'b0, 32'h0000_0055, 32'h0, 5'd9,  1'b0, 1'b0, 1'b0,
                     1'b0, 1'b1, 32'h0000_0055, 5'd9,  1'b0, 1'b0);
        vecs[2] = mk("bubble_sw",   1'b1, 32'h0000_0010, 32'hFFFF_FFFF, 5'd0, 1'b0, 1'b1, 1'b0,
                     1'b0, 1'b0, 32'h0, 5'd0, 1'b1, 1'b0);
        vecs[3] = mk("bubble_rt",   1'b1, 32'h0000_0001, 32'h0, 5'd1,  1'b0, 1'b0, 1'b1,
                     1'b0, 1'b0, 32'h0, 5'd0, 1'b1, 1'b0);
        vecs[4] = mk("addi_max",    1'b0, 32'hFFFF_FFFF, 32'h0, 5'd31, 1'b0, 1'b0, 1'b1,
                     1'b1, 1'b1, 32'hFFFF_FFFF, 5'd31, 1'b0, 1'b0);
        vecs[5] = mk("lw_misalign", 1'b0, 32'h0000_0013, 32'h0, 5'd4,  1'b1, 1'b0, 1'b1,
                     1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b1);
        vecs[6] = mk("rd_and_wr",   1'b0, 32'h0000_0010, 32'h0, 5'd4,  1'b1, 1'b1, 1'b1,
                     1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b1);

        reset = 1'b1;
        nop();
        step();
        step();
        check_reset_outputs("reset_hold");
        reset = 1'b0;
        step();
        check_reset_outputs("reset_release");

        // Preload words 0, 4 and 8.
        do_store("pre_w0", 32'h0000_0000, 32'hA5A5_0000);
        do_store("pre_w8", 32'h0000_0020, 32'h1111_2222);
        do_store("pre_w4", 32'h0000_0010, 32'h0BAD_F00D);

        // Reset must leave memory contents alone.
        reset = 1'b1;
        step();
        check_reset_outputs("reset2");
        reset = 1'b0;
        step();
        do_load("ld_after_reset", 32'h0000_0010, 5'd7, 32'h0BAD_F00D);

        for (int i = 0; i < 7; i++) begin
            stall_in     = vecs[i].stall;
            alu_result   = vecs[i].alu;
            store_data   = vecs[i].sdata;
            rd_in        = vecs[i].rd;
            mem_read     = vecs[i].mr;
            mem_write    = vecs[i].mw;
            reg_write_in = vecs[i].rw;
            step();
            check({vecs[i].name, ".wb_en"},     {31'd0, wb_en},     {31'd0, vecs[i].e_wb_en});
            check({vecs[i].name, ".stall_out"}, {31'd0, stall_out}, {31'd0, vecs[i].e_stall});
            check({vecs[i].name, ".busy"},      {31'd0, busy},      32'd0);
            check({vecs[i].name, ".err"},       {31'd0, err},       {31'd0, vecs[i].e_err});
            if (vecs[i].chk_wb) begin
                check({vecs[i].name, ".wb_data"}, wb_data,        vecs[i].e_data);
                check({vecs[i].name, ".wb_rd"},   {27'd0, wb_rd}, {27'd0, vecs[i].e_rd});
            end
        end
        nop();
        step();
        check("illegal_no_busy", {31'd0, busy}, 32'd0);
        check("err_sticky",      {31'd0, err},  32'd1);

        // The bubbled store must not have written word 4.
        do_load("ld_after_bubble", 32'h0000_0010, 5'd6, 32'h0BAD_F00D);

        // Store then load of the same word returns the new data.
        do_store("sw_beef", 32'h0000_0010, 32'hDEAD_BEEF);
        do_load("lw_beef", 32'h0000_0010, 5'd5, 32'hDEAD_BEEF);

        // Reset during ACCESS of a store to word 8 drops the store.
        nop();
        alu_result = 32'h0000_0020;
        store_data = 32'h9999_9999;
        mem_write  = 1'b1;
        step();
        check("mid_reset.busy_before", {31'd0, busy}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs("mid_reset");
        step();
        step();
        reset = 1'b0;
        nop();
        step();
        check("mid_reset.busy_after", {31'd0, busy}, 32'd0);
        do_load("ld_w8_unchanged", 32'h0000_0020, 5'd8, 32'h1111_2222);

        // Address wrap: byte address 0x400 aliases word 0.
        do_store("sw_wrap", 32'h0000_0400, 32'hCAFE_0001);
        do_load("lw_wrap_w0", 32'h0000_0000, 5'd10, 32'hCAFE_0001);
        do_load("lw_wrap_hi", 32'h0000_0400, 5'd11, 32'hCAFE_0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
